data_frame_tx: RTL and testbench
================================

DATA_FRAME_TX -- requirements
Module: data_frame_tx

Interface
REQ-001 SHALL have parameter HEADER, default 8'b1100_1100, frame header byte sent first.
REQ-002 SHALL have port clk  input  1  system clock (500 kHz); all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_en  input  1  serial bit strobe, one clk wide, one per transmitted bit.
REQ-005 SHALL have port data_i  input  24  payload; data_i[23:16] is sent first.
REQ-006 SHALL have port data_valid_i  input  1  payload offered.
REQ-007 SHALL have port data_ready_o  output  1  block can accept a payload.
REQ-008 SHALL have port ser_o  output  1  serial frame bit, MSB first, to the IQ split stage.
REQ-009 SHALL have port ser_valid_o  output  1  ser_o carries a frame bit.
REQ-010 SHALL have port busy_o  output  1  a frame is in progress.
REQ-011 SHALL have port frame_done_o  output  1  one-clk pulse at the end of a frame.

Function
REQ-012 SHALL build a 40-bit frame {HEADER, data_i[23:16], data_i[15:8], data_i[7:0], SUM}, where SUM = (HEADER + the three payload bytes) mod 256.
REQ-013 SHALL capture the payload and SUM on a clk edge with data_valid_i=1 and data_ready_o=1; data_i may change afterwards.
REQ-014 SHALL implement states IDLE, SEND and TAIL (plus PRE, see Configuration); data_ready_o=1 only in IDLE; busy_o=1 in every other state.
REQ-015 SHALL ignore data_valid_i outside IDLE; no payload is queued.
REQ-016 SHALL ignore a bit_en on the acceptance cycle; the first bit goes out on the first bit_en after acceptance.
REQ-017 SHALL, in SEND, on each bit_en edge, register the next frame bit (bit 39 down to bit 0) onto ser_o and set ser_valid_o=1; ser_o holds between strobes.
REQ-018 SHALL use a 6-bit bit counter and move to TAIL on the edge that launches bit 0 (the 40th strobe).
REQ-019 SHALL, in TAIL, on the next bit_en, drive ser_o=0 and ser_valid_o=0, pulse frame_done_o for one clk, and return to IDLE.
REQ-020 SHALL keep all state unchanged while bit_en=0; irregular strobe spacing is legal.
REQ-021 SHALL keep ser_o=0 and ser_valid_o=0 in IDLE.

Reset
REQ-022 SHALL, with rst_n=0 at any time including mid-frame, immediately force state IDLE, counter 0, shift register 0, ser_o=0, ser_valid_o=0, busy_o=0, frame_done_o=0, data_ready_o=1; the partial frame is discarded.

Configuration
REQ-023 SHALL recognise macro DATA_FRAME_TX_PREAMBLE_EN.
REQ-024 SHALL, when the macro is defined, enter PRE after acceptance and send the 8 bits 1,0,1,0,1,0,1,0 (ser_valid_o=0) on successive bit_en strobes before entering SEND; frame total 48 strobes plus TAIL.
REQ-025 SHALL, when the macro is undefined, contain no PRE state or logic; acceptance goes directly to SEND.

Structure
REQ-026 SHALL take from shared package qpsk_frame_pkg the default HEADER, FRAME_W=40, PAYLOAD_W=24, PREAMBLE=8'b1010_1010 and the state encoding.
REQ-027 SHALL compute SUM in one sub-module, frame_checksum: four 8-bit inputs, an 8-bit mod-256 sum, combinational. The receiver reuses it.

Verification
REQ-028 SHALL test: payload 24'h123456, bit_en every 4 clk -> 40 ser_valid_o bits 40'hCC12345668, then frame_done_o once.
REQ-029 SHALL test: payload 24'hFFFFFF -> 40'hCCFFFFFFC9 (checksum wrap); loopback into the receiver -> valid_flag, and valid_data_o=40'hCCFFFFFFC9.
REQ-030 SHALL test: data_valid_i held high with a new value while busy_o=1 -> no capture, data_ready_o=0; the next frame carries the value present at the return to IDLE.
REQ-031 SHALL test: rst_n low after the 20th bit -> ser_o=0, ser_valid_o=0, data_ready_o=1 at once; the next frame is complete and correct.
REQ-032 SHALL test: bit_en asserted on the acceptance cycle, and a 100-clk strobe gap mid-frame -> neither an extra bit nor a lost bit.
REQ-033 SHALL test: with DATA_FRAME_TX_PREAMBLE_EN defined -> 8'hAA with ser_valid_o=0, then 40'hCC12345668 with ser_valid_o=1.

Source files
------------

// File: rtl/qpsk_frame_pkg.sv
// -----------------------------------------------------------------------------
// qpsk_frame_pkg -- constants and state encoding shared by the frame
// transmitter (data_frame_tx) and the matching receiver.
// Optional feature macro: DATA_FRAME_TX_PREAMBLE_EN (adds the PRE state).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package qpsk_frame_pkg;

    // Frame geometry: header byte, three payload bytes, checksum byte.
    localparam int FRAME_W   = 40;
    localparam int PAYLOAD_W = 24;
    localparam int BYTE_W    = 8;
    localparam int CNT_W     = 6;

    // Default frame header and the alternating preamble pattern.
    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'b1100_1100;
    localparam logic [BYTE_W-1:0] PREAMBLE       = 8'b1010_1010;

    // Counter value on the strobe that launches the last bit of a phase.
    localparam logic [CNT_W-1:0] FRAME_LAST_CNT = 6'd39;
    localparam logic [CNT_W-1:0] PRE_LAST_CNT   = 6'd7;

    // Transmitter state encoding. PRE exists only in the preamble build.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef DATA_FRAME_TX_PREAMBLE_EN
        ST_PRE  = 2'd3,
`endif
        ST_SEND = 2'd1,
        ST_TAIL = 2'd2
    } tx_state_e;

    // Preamble bit for a 0-based launch index, MSB of PREAMBLE first.
    function automatic logic preamble_bit(input logic [2:0] idx);
        return PREAMBLE[3'd7 - idx];
    endfunction

endpackage : qpsk_frame_pkg

// File: rtl/frame_checksum.sv
// -----------------------------------------------------------------------------
// frame_checksum -- combinational mod-256 sum of four bytes. Used by the
// transmitter to build the trailing checksum and by the receiver to verify it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module frame_checksum
    import qpsk_frame_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic [BYTE_W-1:0] c_i,
    input  logic [BYTE_W-1:0] d_i,
    output logic [BYTE_W-1:0] sum_o
);

    // Carries out of bit 7 are dropped: 8-bit result gives the mod-256 wrap.
    // NOTE: sum_o is assigned unconditionally on every path, so no latch can be inferred.
    always_comb begin
        sum_o = a_i + b_i + c_i + d_i;
    end

endmodule : frame_checksum

// File: rtl/data_frame_tx.sv
// -----------------------------------------------------------------------------
// data_frame_tx -- serialises a 24-bit payload into a 40-bit frame
// {HEADER, payload[23:16], payload[15:8], payload[7:0], SUM}, MSB first,
// one bit per bit_en strobe. A single-entry handshake (data_valid_i /
// data_ready_o) accepts a payload only while idle.
// Optional feature macro: DATA_FRAME_TX_PREAMBLE_EN -- when defined, eight
// preamble bits 1010_1010 (ser_valid_o=0) precede the frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module data_frame_tx
    import qpsk_frame_pkg::*;
#(
    parameter logic [BYTE_W-1:0] HEADER = HEADER_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_en,
    input  logic [PAYLOAD_W-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 ser_o,
    output logic                 ser_valid_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    tx_state_e          state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic               ser_q;
    logic               ser_valid_q;
    logic               done_q;

    logic [BYTE_W-1:0]  sum_d;
    logic [FRAME_W-1:0] frame_d;
    logic               accept;

    // Checksum over header and the three payload bytes as currently offered.
    frame_checksum u_checksum (
        .a_i   (HEADER),
        .b_i   (data_i[23:16]),
        .c_i   (data_i[15:8]),
        .d_i   (data_i[7:0]),
        .sum_o (sum_d)
    );

    // Frame image loaded into the shift register on acceptance.
    always_comb begin
        frame_d = {HEADER, data_i, sum_d};
    end

    // Handshake decode; ready is a pure decode of the state register.
    always_comb begin
        data_ready_o = (state_q == ST_IDLE);
        busy_o       = (state_q != ST_IDLE);
        accept       = data_valid_i && data_ready_o;
    end

    // Frame sequencer: acceptance, optional preamble, 40 frame bits, tail.
    // NOTE: all state here is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            // NOTE: the shift register is cleared too, so a frame aborted by reset leaves no stale bits behind.
            shift_q     <= '0;
            ser_q       <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ser_q       <= 1'b0;
                    ser_valid_q <= 1'b0;
                    // A strobe coinciding with acceptance is deliberately ignored.
                    if (accept) begin
                        shift_q   <= frame_d;
                        bit_cnt_q <= '0;
`ifdef DATA_FRAME_TX_PREAMBLE_EN
                        state_q   <= ST_PRE;
`else
                        state_q   <= ST_SEND;
`endif
                    end
                end
`ifdef DATA_FRAME_TX_PREAMBLE_EN
                ST_PRE: begin
                    if (bit_en) begin
                        ser_q       <= preamble_bit(bit_cnt_q[2:0]);
                        ser_valid_q <= 1'b0;
                        if (bit_cnt_q == PRE_LAST_CNT) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_SEND;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
`endif
                ST_SEND: begin
                    if (bit_en) begin
                        ser_q       <= shift_q[FRAME_W-1];
                        ser_valid_q <= 1'b1;
                        shift_q     <= {shift_q[FRAME_W-2:0], 1'b0};
                        if (bit_cnt_q == FRAME_LAST_CNT) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_TAIL;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    // Bit 0 stays on ser_o until the closing strobe.
                    if (bit_en) begin
                        ser_q       <= 1'b0;
                        ser_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Serial outputs come straight from registers.
    always_comb begin
        ser_o        = ser_q;
        ser_valid_o  = ser_valid_q;
        frame_done_o = done_q;
    end

endmodule : data_frame_tx

// File: tb/tb_data_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_data_frame_tx -- directed and randomised checks of data_frame_tx against
// a byte-level frame model; a behavioural receiver recovers frames from ser_o.
// Honours DATA_FRAME_TX_PREAMBLE_EN when the design is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_frame_tx;

    localparam logic [7:0] HDR = 8'hCC;

    logic        clk;
    logic        rst_n;
    logic        bit_en;
    logic [23:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic        ser_o;
    logic        ser_valid_o;
    logic        busy_o;
    logic        frame_done_o;

    int n_pass;
    int n_total;

    data_frame_tx #(.HEADER(HDR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_en       (bit_en),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .ser_o        (ser_o),
        .ser_valid_o  (ser_valid_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    // 500 kHz clock.
    initial clk = 1'b0;
    always #1000 clk = ~clk;

    // Global time limit.
    initial begin
        #(64'd150_000_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame straight from the byte rule: header, payload, byte sum mod 256.
    function automatic logic [39:0] ref_frame(input logic [23:0] p);
        int s;
        s = (int'(HDR) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) % 256;
        return {HDR, p, 8'(s)};
    endfunction

    // Behavioural receiver: frame valid when header matches and checksum agrees.
    function automatic logic rx_flag(input logic [39:0] f);
        int s;
        s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        return (f[39:32] == HDR) && (s == int'(f[7:0]));
    endfunction

    // Offer a payload for one cycle once ready; optionally strobe on that same cycle.
    task automatic accept(input logic [23:0] d, input logic strobe_now);
        int waited;
        waited = 0;
        while (data_ready_o !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        check("accept_ready", 64'(data_ready_o), 64'(1'b1));
        data_i       = d;
        data_valid_i = 1'b1;
        bit_en       = strobe_now;
        tick();
        data_valid_i = 1'b0;
        bit_en       = 1'b0;
        data_i       = 24'($urandom());
        check("accept_busy", 64'(busy_o), 64'(1'b1));
        check("accept_not_ready", 64'(data_ready_o), 64'(1'b0));
        check("accept_no_bit", 64'(ser_valid_o), 64'(1'b0));
    endtask

    // Idle cycles between strobes; outputs must hold and no done pulse may appear.
    task automatic gap(input int n, inout int hold_bad, inout int n_done);
        logic s0;
        logic v0;
        s0 = ser_o;
        v0 = ser_valid_o;
        for (int k = 0; k < n; k++) begin
            tick();
            if (ser_o !== s0 || ser_valid_o !== v0) hold_bad++;
            if (frame_done_o === 1'b1) n_done++;
        end
    endtask

    // Clock one already-accepted frame out and compare it with the model.
    task automatic run_frame(input logic [23:0] p, input int gmin, input int gmax,
                             input int long_at, input string tag, output logic [39:0] got);
        int n_valid;
        int n_done;
        int hold_bad;
        n_valid  = 0;
        n_done   = 0;
        hold_bad = 0;
        got      = '0;
`ifdef DATA_FRAME_TX_PREAMBLE_EN
        begin
            logic [7:0] pre;
            int         pre_valid;
            pre       = '0;
            pre_valid = 0;
            for (int i = 0; i < 8; i++) begin
                bit_en = 1'b1;
                tick();
                bit_en = 1'b0;
                pre = {pre[6:0], ser_o};
                if (ser_valid_o === 1'b1) pre_valid++;
                if (frame_done_o === 1'b1) n_done++;
                gap($urandom_range(gmax, gmin) - 1, hold_bad, n_done);
            end
            check({tag, "_preamble"}, 64'(pre), 64'(8'hAA));
            check({tag, "_preamble_valid"}, 64'(pre_valid), 64'(0));
        end
`endif
        for (int i = 0; i < 40; i++) begin
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            if (ser_valid_o === 1'b1) begin
                n_valid++;
                got = {got[38:0], ser_o};
            end
            if (frame_done_o === 1'b1) n_done++;
            gap($urandom_range(gmax, gmin) - 1, hold_bad, n_done);
            if (i == long_at) gap(100, hold_bad, n_done);
        end
        check({tag, "_frame"}, 64'(got), 64'(ref_frame(p)));
        check({tag, "_nvalid"}, 64'(n_valid), 64'(40));
        check({tag, "_early_done"}, 64'(n_done), 64'(0));
        check({tag, "_hold"}, 64'(hold_bad), 64'(0));
        check({tag, "_busy_before_tail"}, 64'(busy_o), 64'(1'b1));
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        check({tag, "_done"}, 64'(frame_done_o), 64'(1'b1));
        check({tag, "_tail_ser"}, 64'({ser_o, ser_valid_o}), 64'(2'b00));
        check({tag, "_tail_ready"}, 64'(data_ready_o), 64'(1'b1));
        tick();
        check({tag, "_done_one_clk"}, 64'(frame_done_o), 64'(1'b0));
    endtask

    initial begin
        logic [39:0] got;
        logic [23:0] p;
        n_pass       = 0;
        n_total      = 0;
        rst_n        = 1'b0;
        bit_en       = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;
        #1;
        check("rst_ser", 64'(ser_o), 64'(1'b0));
        check("rst_ser_valid", 64'(ser_valid_o), 64'(1'b0));
        check("rst_busy", 64'(busy_o), 64'(1'b0));
        check("rst_done", 64'(frame_done_o), 64'(1'b0));
        check("rst_ready", 64'(data_ready_o), 64'(1'b1));
        repeat (3) tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Basic frame, strobe every 4 clk.
        accept(24'h123456, 1'b0);
        run_frame(24'h123456, 4, 4, -1, "basic", got);
        check("basic_const", 64'(got), 64'(40'hCC12345668));

        // Checksum wrap and loopback into the behavioural receiver.
        accept(24'hFFFFFF, 1'b0);
        run_frame(24'hFFFFFF, 2, 3, -1, "wrap", got);
        check("wrap_const", 64'(got), 64'(40'hCCFFFFFFC9));
        check("rx_valid_flag", 64'(rx_flag(got)), 64'(1'b1));
        check("rx_valid_data", 64'(rx_flag(got) ? got : 40'h0), 64'(40'hCCFFFFFFC9));

        // Payload offered while busy is ignored; value at return to idle is taken.
        accept(24'hA5A5A5, 1'b0);
        data_valid_i = 1'b1;
        data_i       = 24'h5A5A5A;
        tick();
        check("busy_hold_not_ready", 64'(data_ready_o), 64'(1'b0));
        check("busy_hold_busy", 64'(busy_o), 64'(1'b1));
        data_i = 24'h3C0FF0;
        run_frame(24'hA5A5A5, 2, 4, -1, "hold_first", got);
        data_valid_i = 1'b0;
        check("hold_recaptured", 64'(busy_o), 64'(1'b1));
        run_frame(24'h3C0FF0, 2, 4, -1, "hold_second", got);

        // Reset after the 20th strobe discards the frame.
        accept(24'h0F1E2D, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            tick();
        end
        #400;
        rst_n = 1'b0;
        #1;
        check("midrst_ser", 64'(ser_o), 64'(1'b0));
        check("midrst_ser_valid", 64'(ser_valid_o), 64'(1'b0));
        check("midrst_ready", 64'(data_ready_o), 64'(1'b1));
        check("midrst_busy", 64'(busy_o), 64'(1'b0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        accept(24'h0F1E2D, 1'b0);
        run_frame(24'h0F1E2D, 3, 3, -1, "after_rst", got);

        // Strobe on the acceptance cycle plus a 100-clk gap mid-frame.
        accept(24'hC3D2E1, 1'b1);
        run_frame(24'hC3D2E1, 3, 3, 17, "gap", got);

        // Randomised payloads and strobe spacing.
        for (int r = 0; r < 5; r++) begin
            p = 24'($urandom());
            accept(p, 1'($urandom_range(1, 0)));
            run_frame(p, 1, 6, -1, "rand", got);
            check("rand_rx_flag", 64'(rx_flag(got)), 64'(1'b1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_data_frame_tx
